// File: rtl/nf_pwm_seq.sv
// nf_pwm_seq: register-programmed duty FIFO that writes one duty value to a PWM slave every PERIOD+1 cycles
module nf_pwm_seq #(
    parameter int          DEPTH         = 8,
    parameter logic [31:0] PWM_DUTY_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic [31:0] pwm_addr,
    output logic        pwm_we,
    output logic [31:0] pwm_wd
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, COUNT, LOAD} state_t;
    state_t        state;
    logic [1:0]    ctrl;
    logic [31:0]   period, cnt, last_wd, limit;
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] head, tail;
    logic [AW:0]   fill;
    logic          ovf, unf, full, empty, pop, recirc, push_bus, push;
    logic          wr_ctrl, wr_period, wr_data, wr_status, unused;

    assign unused    = ^{addr[31:4], addr[1:0]};
    assign wr_ctrl   = we && addr[3:2] == 2'd0;
    assign wr_period = we && addr[3:2] == 2'd1;
    assign wr_data   = we && addr[3:2] == 2'd2;
    assign wr_status = we && addr[3:2] == 2'd3;
    assign full      = fill == (AW+1)'(DEPTH);
    assign empty     = fill == '0;
    assign limit     = (period == 32'd0) ? 32'd0 : period - 32'd1;
    assign pop       = state == LOAD && !empty;
    assign recirc    = pop && ctrl[1];
    // a pop in the same cycle frees a slot, so a non-loop push never overflows then
    assign push_bus  = wr_data && (pop ? !ctrl[1] : !full);
    assign push      = recirc || push_bus;
    assign pwm_we    = pop && !reset;
    assign pwm_wd    = pwm_we ? mem[head] : last_wd;
    assign pwm_addr  = PWM_DUTY_ADDR;

    always_comb
        rd = addr[3:2] == 2'd0 ? {30'd0, ctrl} :
             addr[3:2] == 2'd1 ? period :
             addr[3:2] == 2'd2 ? 32'd0 :
             {19'd0, 5'(fill), 4'd0, unf, ovf, full, empty};

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            ctrl    <= '0;
            period  <= '0;
            head    <= '0;
            tail    <= '0;
            fill    <= '0;
            ovf     <= 1'b0;
            unf     <= 1'b0;
            last_wd <= '0;
        end else begin
            if (wr_ctrl) ctrl <= wd[1:0];
            if (wr_period) period <= wd;
            if (push) begin
                mem[tail] <= recirc ? mem[head] : wd;
                tail      <= tail + AW'(1);
            end
            if (pop) begin
                head    <= head + AW'(1);
                last_wd <= mem[head];
            end
            fill <= fill + (AW+1)'(push) - (AW+1)'(pop);
            ovf  <= (ovf && !(wr_status && wd[2])) || (wr_data && !push_bus);
            unf  <= (unf && !(wr_status && wd[3])) || (state == LOAD && empty);
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (ctrl[0]) state <= COUNT;
                end
                COUNT: begin
                    if (!ctrl[0]) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt >= limit) begin
                        state <= LOAD;
                        cnt   <= '0;
                    end else cnt <= cnt + 32'd1;
                end
                default: begin
                    state <= ctrl[0] ? COUNT : IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_nf_pwm_seq.sv
// tb_nf_pwm_seq: directed scenario tests for nf_pwm_seq with hand-computed expectations
module tb_nf_pwm_seq;
    localparam logic [31:0] DUTY = 32'hA000_0010;
    localparam logic [31:0] A_CTRL = 32'h0, A_PER = 32'h4, A_DATA = 32'h8, A_STAT = 32'hC;
    logic        clk = 1'b0, reset, we;
    logic [31:0] addr, wd, rd, pwm_addr, pwm_wd;
    logic        pwm_we;
    int          n_cmp = 0, n_err = 0;

    nf_pwm_seq #(.DEPTH(8), .PWM_DUTY_ADDR(DUTY)) dut (
        .clk(clk), .reset(reset), .addr(addr), .we(we), .wd(wd), .rd(rd),
        .pwm_addr(pwm_addr), .pwm_we(pwm_we), .pwm_wd(pwm_wd)
    );

    always #5 clk = ~clk;

    // called at a negedge; the write lands on the next posedge, returns at the following negedge
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr = a; wd = d; we = 1'b1;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic rd_reg(input logic [31:0] a, output logic [31:0] v);
        addr = a;
        #1 v = rd;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; we = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        reset = 1'b1; we = 1'b0; addr = '0; wd = '0;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (pwm_we !== 1'b0) begin n_err++; $display("FAIL reset_we got %b exp 0", pwm_we); end
        n_cmp++; if (pwm_wd !== 32'd0) begin n_err++; $display("FAIL reset_wd got %h exp 0", pwm_wd); end
        n_cmp++; if (pwm_addr !== DUTY) begin n_err++; $display("FAIL reset_addr got %h exp %h", pwm_addr, DUTY); end
        reset = 1'b0;
        @(negedge clk);
        rd_reg(A_STAT, v);
        n_cmp++; if (v !== 32'h1) begin n_err++; $display("FAIL reset_status got %h exp 1", v); end
        rd_reg(A_CTRL, v);
        n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL reset_ctrl got %h exp 0", v); end
        rd_reg(A_PER, v);
        n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL reset_period got %h exp 0", v); end
    endtask

    task automatic test_basic();
        logic [31:0] v;
        logic        e;
        do_reset();
        bus_write(A_PER, 32'd4);
        bus_write(A_DATA, 32'd10); bus_write(A_DATA, 32'd20); bus_write(A_DATA, 32'd30);
        bus_write(A_CTRL, 32'h1);
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            e = (c == 5 || c == 10 || c == 15);
            n_cmp++; if (pwm_we !== e) begin n_err++; $display("FAIL basic_we c=%0d got %b exp %b", c, pwm_we, e); end
            if (e) begin
                n_cmp++;
                if (pwm_wd !== 32'(c * 2)) begin n_err++; $display("FAIL basic_wd c=%0d got %0d exp %0d", c, pwm_wd, c * 2); end
            end
        end
        rd_reg(A_STAT, v);
        n_cmp++; if (v !== 32'h9) begin n_err++; $display("FAIL basic_status got %h exp 9", v); end
        n_cmp++; if (pwm_addr !== DUTY) begin n_err++; $display("FAIL basic_addr got %h exp %h", pwm_addr, DUTY); end
    endtask

    task automatic test_full_ovf();
        logic [31:0] v;
        do_reset();
        for (int i = 0; i < 9; i++) bus_write(A_DATA, 32'(100 + i));
        rd_reg(A_STAT, v);
        n_cmp++; if (v !== 32'h806) begin n_err++; $display("FAIL full_status got %h exp 806", v); end
        rd_reg(A_DATA, v);
        n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL data_read got %h exp 0", v); end
        bus_write(A_STAT, 32'h4);
        rd_reg(A_STAT, v);
        n_cmp++; if (v !== 32'h802) begin n_err++; $display("FAIL ovf_clear got %h exp 802", v); end
    endtask

    task automatic test_loop();
        logic [31:0] v;
        logic        e;
        do_reset();
        bus_write(A_PER, 32'd2);
        bus_write(A_DATA, 32'd1); bus_write(A_DATA, 32'd2);
        bus_write(A_CTRL, 32'h3);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            e = (c % 3 == 0);
            n_cmp++; if (pwm_we !== e) begin n_err++; $display("FAIL loop_we c=%0d got %b exp %b", c, pwm_we, e); end
            if (e) begin
                n_cmp++;
                if (pwm_wd !== ((c % 6 == 0) ? 32'd2 : 32'd1)) begin n_err++; $display("FAIL loop_wd c=%0d got %0d", c, pwm_wd); end
            end
        end
        bus_write(A_DATA, 32'd55);
        rd_reg(A_STAT, v);
        n_cmp++; if (v !== 32'h204) begin n_err++; $display("FAIL loop_status got %h exp 204", v); end
    endtask

    task automatic test_period0();
        logic e;
        do_reset();
        bus_write(A_DATA, 32'd7); bus_write(A_DATA, 32'd8);
        bus_write(A_CTRL, 32'h1);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            e = (c == 2 || c == 4);
            n_cmp++; if (pwm_we !== e) begin n_err++; $display("FAIL p0_we c=%0d got %b exp %b", c, pwm_we, e); end
            if (e) begin
                n_cmp++;
                if (pwm_wd !== ((c == 2) ? 32'd7 : 32'd8)) begin n_err++; $display("FAIL p0_wd c=%0d got %0d", c, pwm_wd); end
            end
        end
        n_cmp++; if (pwm_wd !== 32'd8) begin n_err++; $display("FAIL p0_hold got %0d exp 8", pwm_wd); end
    endtask

    task automatic test_en_clear();
        int early;
        do_reset();
        bus_write(A_PER, 32'd100);
        bus_write(A_DATA, 32'd5);
        bus_write(A_CTRL, 32'h1);
        repeat (50) @(negedge clk);
        bus_write(A_CTRL, 32'h0);
        early = 0;
        for (int c = 0; c < 150; c++) begin
            @(negedge clk);
            if (pwm_we !== 1'b0) early++;
        end
        n_cmp++; if (early != 0) begin n_err++; $display("FAIL enclr_idle got %0d pulses exp 0", early); end
        bus_write(A_CTRL, 32'h1);
        early = 0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (pwm_we !== 1'b0) early++;
        end
        n_cmp++; if (early != 0) begin n_err++; $display("FAIL reen_early got %0d pulses exp 0", early); end
        @(negedge clk);
        n_cmp++; if (pwm_we !== 1'b1) begin n_err++; $display("FAIL reen_we got %b exp 1", pwm_we); end
        n_cmp++; if (pwm_wd !== 32'd5) begin n_err++; $display("FAIL reen_wd got %0d exp 5", pwm_wd); end
    endtask

    task automatic test_period_change();
        do_reset();
        bus_write(A_PER, 32'd100);
        bus_write(A_DATA, 32'd4);
        bus_write(A_CTRL, 32'h1);
        repeat (30) @(negedge clk);
        bus_write(A_PER, 32'd10);
        n_cmp++; if (pwm_we !== 1'b0) begin n_err++; $display("FAIL perchg_pre got %b exp 0", pwm_we); end
        @(negedge clk);
        n_cmp++; if (pwm_we !== 1'b1) begin n_err++; $display("FAIL perchg_we got %b exp 1", pwm_we); end
        n_cmp++; if (pwm_wd !== 32'd4) begin n_err++; $display("FAIL perchg_wd got %0d exp 4", pwm_wd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        do_reset();
        for (int i = 1; i <= 8; i++) bus_write(A_DATA, 32'(i));
        bus_write(A_CTRL, 32'h1);
        repeat (2) @(negedge clk);
        n_cmp++; if (pwm_we !== 1'b1 || pwm_wd !== 32'd1) begin n_err++; $display("FAIL b2b_load got we=%b wd=%0d exp 1/1", pwm_we, pwm_wd); end
        bus_write(A_DATA, 32'd99);
        rd_reg(A_STAT, v);
        n_cmp++; if (v !== 32'h802) begin n_err++; $display("FAIL b2b_status got %h exp 802", v); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        int          cnt_we;
        do_reset();
        bus_write(A_DATA, 32'd1); bus_write(A_DATA, 32'd2); bus_write(A_DATA, 32'd3);
        bus_write(A_CTRL, 32'h1);
        repeat (2) @(negedge clk);
        reset = 1'b1; addr = A_CTRL; wd = 32'h3; we = 1'b1;
        #1;
        n_cmp++; if (pwm_we !== 1'b0) begin n_err++; $display("FAIL rstmid_we0 got %b exp 0", pwm_we); end
        @(negedge clk);
        reset = 1'b0; we = 1'b0;
        #1;
        n_cmp++; if (pwm_we !== 1'b0) begin n_err++; $display("FAIL rstmid_we1 got %b exp 0", pwm_we); end
        rd_reg(A_STAT, v);
        n_cmp++; if (v !== 32'h1) begin n_err++; $display("FAIL rstmid_status got %h exp 1", v); end
        rd_reg(A_CTRL, v);
        n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL rstmid_ctrl got %h exp 0", v); end
        rd_reg(A_PER, v);
        n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL rstmid_period got %h exp 0", v); end
        cnt_we = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (pwm_we !== 1'b0) cnt_we++;
        end
        n_cmp++; if (cnt_we != 0) begin n_err++; $display("FAIL rstmid_quiet got %0d pulses exp 0", cnt_we); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_ovf();
        test_loop();
        test_period0();
        test_en_clear();
        test_period_change();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
